seq_mult_arbiter: RTL and testbench
===================================

// Module: seq_mult_arbiter
// PURPOSE
//  Shares one external seq_multiplier (shift-add, BIT_WIDTH cycles/op) among NUM_REQ requesters.
//  Round-robin grant, valid/ready handshake per requester. Sequences mult load/enable, captures
//  the 2*BIT_WIDTH product and returns it with the requester id over a single response channel.
// PARAMETERS
//  BIT_WIDTH  4  operand width; must match the attached seq_multiplier
//  NUM_REQ    4  requester count (>=2); ID_W = $clog2(NUM_REQ)
// PORTS
//  clk           in   1              clock, rising edge
//  reset_n       in   1              asynchronous active-low reset
//  req_valid     in   NUM_REQ        request pending, one bit per requester
//  req_ready     out  NUM_REQ        one-hot grant/accept; a request is taken when valid&ready
//  req_factor1   in   NUM_REQ*BIT_W  flat operand A, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//  req_factor2   in   NUM_REQ*BIT_W  flat operand B, same packing
//  rsp_valid     out  1              response available
//  rsp_ready     in   1              consumer accepts response
//  rsp_product   out  2*BIT_WIDTH    A*B, unsigned
//  rsp_id        out  ID_W           index of requester that issued the operation
//  busy          out  1              1 whenever state != IDLE
//  mult_reset    out  1              to multiplier reset (active-high sync) = ~reset_n
//  mult_load     out  1              to multiplier load
//  mult_enable   out  1              to multiplier enable
//  mult_factor1  out  BIT_WIDTH      to multiplier factor1 (registered operand A)
//  mult_factor2  out  BIT_WIDTH      to multiplier factor2 (registered operand B)
//  mult_product  in   2*BIT_WIDTH    from multiplier product (nonzero only when its count==BIT_WIDTH)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, rr pointer=0, all registered outputs 0 (req_ready,
//   rsp_valid, rsp_product, rsp_id, busy, mult_load, mult_enable, mult_factor1/2); in-flight job
//   dropped, no response produced. Outputs take reset values immediately, not at next edge.
//  FSM IDLE -> LOAD -> RUN -> CAPTURE -> RESP -> IDLE.
//  IDLE: req_ready combinational: one-hot on winner = first i with req_valid[i], searching
//   rr_ptr, rr_ptr+1, ... mod NUM_REQ. All zero if no req_valid. On the accepting edge latch
//   factor1/2 of winner into mult_factor1/2, winner into rsp_id; go LOAD.
//   Requester may drop valid before ready; nothing is committed until the handshake.
//  LOAD (1 cycle): mult_load=1. -> RUN, cnt=0.
//  RUN (BIT_WIDTH cycles): mult_enable=1; cnt increments each cycle; leave when cnt==BIT_WIDTH-1.
//   cnt width $clog2(BIT_WIDTH+1).
//  CAPTURE (1 cycle): mult_load=mult_enable=0; rsp_product <= mult_product. -> RESP.
//  RESP: rsp_valid=1; rsp_product and rsp_id held stable until rsp_valid&rsp_ready; then
//   rsp_valid=0, rr_ptr <= (rsp_id+1) mod NUM_REQ, -> IDLE.
//  req_ready is 0 in every state except IDLE; mult_load and mult_enable never both 1.
//  Latency: accept edge in cycle T -> rsp_valid first high in cycle T+BIT_WIDTH+3 (T+7 at W=4).
//   Min issue interval BIT_WIDTH+4 cycles with rsp_ready=1 (next accept in cycle after rsp handshake).
//  Arithmetic: unsigned, full 2*BIT_WIDTH result, no overflow possible.
//  Fairness: a continuously asserting requester waits at most NUM_REQ-1 operations.
//  rr_ptr wraps NUM_REQ-1 -> 0. mult_factor1/2 hold last operands outside active job.
// TESTING (BIT_WIDTH=4, NUM_REQ=4)
//  T1 req0 only, A=3 B=5 -> req_ready=4'b0001 one cycle; rsp_valid at T+7, product=15, id=0.
//  T2 req2, A=15 B=15 -> product=225 (8'hE1), id=2; mult_enable high exactly 4 cycles.
//  T3 all four valid, A=i+1 B=2, held -> grants 0,1,2,3,0; products 2,4,6,8,2; ids in order.
//  T4 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/product/id stable; req_ready stays 0 throughout.
//  T5 reset_n low mid-RUN -> rsp_valid, busy, mult_enable 0 immediately, no response; after
//   release req1 and req3 valid -> req1 granted first (rr_ptr=0), correct products.
//  T6 A=0 B=9 and A=9 B=0 -> product=0 both; id correct; latency unchanged.

Source files
------------

// File: rtl/seq_mult_arbiter.sv
// seq_mult_arbiter: round-robin front end that shares one external shift-add multiplier
// among several valid/ready requesters and returns tagged products on one response channel.
module seq_mult_arbiter #(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned NUM_REQ   = 4,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_factor1,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_factor2,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [2*BIT_WIDTH-1:0]       rsp_product,
  output logic [ID_W-1:0]              rsp_id,
  output logic                         busy,
  output logic                         mult_reset,
  output logic                         mult_load,
  output logic                         mult_enable,
  output logic [BIT_WIDTH-1:0]         mult_factor1,
  output logic [BIT_WIDTH-1:0]         mult_factor2,
  input  logic [2*BIT_WIDTH-1:0]       mult_product
);

  localparam int unsigned      CNT_W    = $clog2(BIT_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      scan_id;
  logic                 win_found;
  logic [BIT_WIDTH-1:0] win_f1;
  logic [BIT_WIDTH-1:0] win_f2;
  logic                 accept;
  logic                 rsp_fire;

  // The multiplier's synchronous reset simply follows the block reset.
  assign mult_reset = ~reset_n;

  // Round-robin search: first valid requester starting at rr_ptr, plus its operands.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    win_f1    = '0;
    win_f2    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_id = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) begin
        win_f1 = req_factor1[i*BIT_WIDTH +: BIT_WIDTH];
        win_f2 = req_factor2[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Next-state logic; req_ready is the only combinational handshake output.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready = NUM_REQ'(1) << win_id;
          accept    = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD:    state_d = S_RUN;
      S_RUN:     if (cnt_q == CNT_LAST) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // State register; reset drops any in-flight job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath and registered outputs, decoded from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      mult_factor1 <= '0;
      mult_factor2 <= '0;
      rsp_id       <= '0;
      rsp_product  <= '0;
      rsp_valid    <= 1'b0;
      busy         <= 1'b0;
      mult_load    <= 1'b0;
      mult_enable  <= 1'b0;
    end else begin
      if (accept) begin
        mult_factor1 <= win_f1;
        mult_factor2 <= win_f2;
        rsp_id       <= win_id;
      end
      if (state_q == S_LOAD)      cnt_q <= '0;
      else if (state_q == S_RUN)  cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == S_CAPTURE)   rsp_product <= mult_product;
      if (rsp_fire) rr_ptr_q <= (rsp_id == ID_LAST) ? '0 : rsp_id + ID_W'(1);
      busy        <= (state_d != S_IDLE);
      mult_load   <= (state_d == S_LOAD);
      mult_enable <= (state_d == S_RUN);
      rsp_valid   <= (state_d == S_RESP);
    end
  end

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// tb_seq_mult_arbiter: directed bench with a behavioural shift-add multiplier attached.
module tb_seq_mult_arbiter;

  localparam int unsigned BW  = 4;
  localparam int unsigned NR  = 4;
  localparam int unsigned IDW = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NR-1:0]      req_valid = '0;
  logic [NR-1:0]      req_ready;
  logic [NR*BW-1:0]   req_factor1 = '0;
  logic [NR*BW-1:0]   req_factor2 = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [2*BW-1:0]    rsp_product;
  logic [IDW-1:0]     rsp_id;
  logic               busy;
  logic               mult_reset;
  logic               mult_load;
  logic               mult_enable;
  logic [BW-1:0]      mult_factor1;
  logic [BW-1:0]      mult_factor2;
  logic [2*BW-1:0]    mult_product;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_mult_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_factor1(req_factor1), .req_factor2(req_factor2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_product(rsp_product), .rsp_id(rsp_id), .busy(busy),
    .mult_reset(mult_reset), .mult_load(mult_load), .mult_enable(mult_enable),
    .mult_factor1(mult_factor1), .mult_factor2(mult_factor2),
    .mult_product(mult_product)
  );

  // Behavioural shift-add multiplier: one partial product per enabled cycle.
  logic [BW-1:0]   m_a, m_b;
  logic [2*BW-1:0] m_acc;
  logic [2:0]      m_cnt;
  always @(posedge clk) begin
    if (mult_reset) begin
      m_acc <= '0;
      m_cnt <= '0;
    end else if (mult_load) begin
      m_a   <= mult_factor1;
      m_b   <= mult_factor2;
      m_acc <= '0;
      m_cnt <= '0;
    end else if (mult_enable && m_cnt < 3'd4) begin
      if (m_b[m_cnt[1:0]]) m_acc <= m_acc + ({4'b0000, m_a} << m_cnt);
      m_cnt <= m_cnt + 3'd1;
    end
  end
  assign mult_product = (m_cnt == 3'd4) ? m_acc : '0;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] f1;
    logic [15:0] f2;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_prod;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One full transaction, called and returning at a falling edge.
  task automatic run_txn(input string nm, input logic [3:0] valid, input logic [15:0] f1,
                         input logic [15:0] f2, input logic [3:0] exp_ready,
                         input logic [7:0] exp_prod, input logic [1:0] exp_id, input bit hold);
    int lat;
    int en_cnt;
    bit both;
    req_valid   = valid;
    req_factor1 = f1;
    req_factor2 = f2;
    rsp_ready   = 1'b1;
    #1;
    chk({nm, ".ready"}, 32'(req_ready), 32'(exp_ready));
    @(negedge clk);
    if (!hold) req_valid = '0;
    lat = 1; en_cnt = 0; both = 1'b0;
    chk({nm, ".load"}, 32'(mult_load), 32'd1);
    while (!rsp_valid && lat < 20) begin
      if (mult_enable) en_cnt++;
      if (mult_load && mult_enable) both = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'd7);
    chk({nm, ".enable_cycles"}, 32'(en_cnt), 32'd4);
    chk({nm, ".load_and_enable"}, 32'(both), 32'd0);
    chk({nm, ".product"}, 32'(rsp_product), 32'(exp_prod));
    chk({nm, ".id"}, 32'(rsp_id), 32'(exp_id));
    chk({nm, ".ready_in_resp"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({nm, ".rsp_cleared"}, 32'(rsp_valid), 32'd0);
    chk({nm, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int stray;
    logic [3:0] er;

    vecs[0] = '{4'b0001, 16'h0003, 16'h0005, 4'b0001, 8'd15,  2'd0};
    vecs[1] = '{4'b0100, 16'h0F00, 16'h0F00, 4'b0100, 8'd225, 2'd2};
    vecs[2] = '{4'b0001, 16'h0000, 16'h0009, 4'b0001, 8'd0,   2'd0};
    vecs[3] = '{4'b0010, 16'h0090, 16'h0000, 4'b0010, 8'd0,   2'd1};
    vecs[4] = '{4'b1001, 16'h7002, 16'h600B, 4'b1000, 8'd42,  2'd3};
    vecs[5] = '{4'b1001, 16'h7002, 16'h600B, 4'b0001, 8'd22,  2'd0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.mult_load", 32'(mult_load), 32'd0);
    chk("rst.mult_enable", 32'(mult_enable), 32'd0);
    chk("rst.mult_factor1", 32'(mult_factor1), 32'd0);
    chk("rst.rsp_product", 32'(rsp_product), 32'd0);
    chk("rst.rsp_id", 32'(rsp_id), 32'd0);
    chk("rst.mult_reset", 32'(mult_reset), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("run.mult_reset", 32'(mult_reset), 32'd0);

    // Table vectors: single requesters, zero operands, pointer wrap
    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].valid, vecs[i].f1, vecs[i].f2,
              vecs[i].exp_ready, vecs[i].exp_prod, vecs[i].exp_id, 1'b0);

    // Response back-pressure: everything holds, no new grants
    req_valid = 4'b0001; req_factor1 = 16'h0005; req_factor2 = 16'h0003; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("stall.latency", 32'(lat), 32'd7);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall.product", 32'(rsp_product), 32'd15);
      chk("stall.id", 32'(rsp_id), 32'd0);
      chk("stall.req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("stall.rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("stall.idle", 32'(busy), 32'd0);

    // Reset in the middle of RUN: immediate clear, no response, pointer back to 0
    req_valid = 4'b0100; req_factor1 = 16'h0600; req_factor2 = 16'h0700;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("abort.enable_before", 32'(mult_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.mult_enable", 32'(mult_enable), 32'd0);
    chk("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort.mult_factor1", 32'(mult_factor1), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) stray++;
    end
    chk("abort.no_response", 32'(stray), 32'd0);
    run_txn("abort_a", 4'b1010, 16'h5030, 16'h5040, 4'b0010, 8'd12, 2'd1, 1'b0);
    run_txn("abort_b", 4'b1000, 16'h5030, 16'h5040, 4'b1000, 8'd25, 2'd3, 1'b0);

    // All four held valid: strict rotation at the minimum issue interval
    for (int i = 0; i < 5; i++) begin
      er = 4'b0001 << (i % 4);
      run_txn($sformatf("rr%0d", i), 4'b1111, 16'h4321, 16'h2222, er,
              8'(2 * ((i % 4) + 1)), 2'(i % 4), 1'b1);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("end.idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
